// File: rtl/wb_pkg.sv
// ---------------------------------------------------------------------------
// wb_pkg
// Shared types and default sizes for the multi-port writeback unit.
//   XLEN_DEF   : register width in bits
//   NREGS_DEF  : architectural register count
//   NPORTS_DEF : write ports carried by one committed packet
//   NRD_DEF    : combinational read ports
//   CNTW_DEF   : width of each per-register scoreboard in-flight counter
//   wb_pkt_t   : packet handed over by the execute stage
//   wb_state_t : writeback control states
// ---------------------------------------------------------------------------
package wb_pkg;

    localparam int XLEN_DEF   = 64;
    localparam int NREGS_DEF  = 16;
    localparam int NPORTS_DEF = 2;
    localparam int NRD_DEF    = 2;
    localparam int CNTW_DEF   = 2;
    localparam int IDXW_DEF   = $clog2(NREGS_DEF);

    // The packet layout follows the package default sizes, so a top-level
    // instance must keep XLEN/NREGS/NPORTS equal to these defaults.
    typedef struct packed {
        logic [NPORTS_DEF-1:0]                wen;
        logic [NPORTS_DEF-1:0][IDXW_DEF-1:0]  widx;
        logic [NPORTS_DEF-1:0][XLEN_DEF-1:0]  wdata;
        logic                                 is_store;
        logic                                 sim_end;
    } wb_pkt_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        HALT = 2'd2
    } wb_state_t;

endpackage

// File: rtl/mod_wb_scoreboard.sv
// ---------------------------------------------------------------------------
// mod_wb_scoreboard
// One saturating in-flight counter per architectural register. Decode bumps
// a counter when it issues a writer of that register; writeback lowers it
// when the write commits.
//   clk          : clock, state updates on rising edge
//   reset_ni     : synchronous active-low reset, clears every counter
//   set_valid_i  : decode issues an instruction writing set_idx_i
//   set_idx_i    : destination register being issued
//   dec_valid_i  : per write port, a committed write is present
//   dec_idx_i    : per write port, register index of that write
//   busy_o       : bit i high when counter i is nonzero
//   full_o       : counter addressed by set_idx_i is at its maximum
// ---------------------------------------------------------------------------
module mod_wb_scoreboard #(
    parameter int NREGS  = 16,
    parameter int CNTW   = 2,
    parameter int NPORTS = 2,
    localparam int IDXW  = $clog2(NREGS)
) (
    input  logic                             clk,
    input  logic                             reset_ni,
    input  logic                             set_valid_i,
    input  logic [IDXW-1:0]                  set_idx_i,
    input  logic [NPORTS-1:0]                dec_valid_i,
    input  logic [NPORTS-1:0][IDXW-1:0]      dec_idx_i,
    output logic [NREGS-1:0]                 busy_o,
    output logic                             full_o
);

    localparam logic [CNTW-1:0] CNT_MAX = '1;
    localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

    logic [NREGS-1:0][CNTW-1:0] cnt_q;
    logic [NREGS-1:0][CNTW-1:0] cnt_d;
    logic [NREGS-1:0]           inc_hit;
    logic [NREGS-1:0]           dec_hit;

    // Collapse the per-port decrements onto registers: two ports naming the
    // same register still count as a single decrement.
    always_comb begin
        inc_hit = '0;
        dec_hit = '0;
        for (int i = 0; i < NREGS; i++) begin
            inc_hit[i] = set_valid_i && (set_idx_i == IDXW'(i));
            for (int p = 0; p < NPORTS; p++) begin
                if (dec_valid_i[p] && (dec_idx_i[p] == IDXW'(i))) begin
                    dec_hit[i] = 1'b1;
                end
            end
        end
    end

    // A simultaneous issue and retire cancel out even at the maximum, so a
    // full counter stays full instead of losing the new writer. Otherwise
    // increments saturate and decrements stop at zero.
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < NREGS; i++) begin
            if (inc_hit[i] && dec_hit[i]) begin
                cnt_d[i] = cnt_q[i];
            end else if (inc_hit[i] && (cnt_q[i] != CNT_MAX)) begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end else if (dec_hit[i] && (cnt_q[i] != '0)) begin
                cnt_d[i] = cnt_q[i] - CNT_ONE;
            end
        end
    end

    // Counter storage.
    always_ff @(posedge clk) begin
        if (!reset_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Status views for decode.
    always_comb begin
        busy_o = '0;
        for (int i = 0; i < NREGS; i++) begin
            busy_o[i] = (cnt_q[i] != '0);
        end
        full_o = (cnt_q[set_idx_i] == CNT_MAX);
    end

endmodule

// File: rtl/mod_writeback_mp.sv
// ---------------------------------------------------------------------------
// mod_writeback_mp
// Multi-port writeback stage: commits execute-stage packets into the
// register file, holds stores until the memory stage finishes them, tracks
// in-flight writers per register and stops the machine on a sim_end packet.
//   clk                   : clock, state updates on rising edge
//   reset                 : synchronous active-low reset
//   in_valid / in_ready   : packet handshake with execute
//   in_pkt                : per-port wen/widx/wdata plus is_store, sim_end
//   store_memstage_active : memory stage has completed the pending store
//   sb_set_valid/_idx     : decode issues a writer of sb_set_idx
//   sb_full               : counter of sb_set_idx saturated, decode stalls
//   sb_busy               : per-register nonzero in-flight counter
//   rd_idx / rd_data      : combinational read ports with commit bypass
//   store_wb_flag         : one-cycle pulse after a store commits
//   sim_done              : simulation end reached
// ---------------------------------------------------------------------------
module mod_writeback_mp
    import wb_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int NPORTS = NPORTS_DEF,
    parameter int NRD    = NRD_DEF,
    parameter int CNTW   = CNTW_DEF,
    localparam int IDXW  = $clog2(NREGS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  wb_pkt_t                     in_pkt,
    input  logic                        store_memstage_active,
    input  logic                        sb_set_valid,
    input  logic [IDXW-1:0]             sb_set_idx,
    output logic                        sb_full,
    output logic [NREGS-1:0]            sb_busy,
    input  logic [NRD-1:0][IDXW-1:0]    rd_idx,
    output logic [NRD-1:0][XLEN-1:0]    rd_data,
    output logic                        store_wb_flag,
    output logic                        sim_done
);

    wb_state_t                  state_q;
    wb_state_t                  state_d;
    wb_pkt_t                    pkt_q;
    wb_pkt_t                    pkt_d;
    logic                       store_wb_flag_q;
    logic                       store_wb_flag_d;
    logic [NREGS-1:0][XLEN-1:0] rf_q;
    logic [NREGS-1:0][XLEN-1:0] rf_d;

    logic                       commit;
    wb_pkt_t                    commit_pkt;
    logic [NPORTS-1:0]          dec_valid;

    // Control: non-stores commit straight from the input, stores are parked
    // in pkt_q and committed from HOLD once memory reports completion. The
    // store always spends at least one cycle in HOLD, even if memory is
    // already done when it arrives.
    always_comb begin
        state_d    = state_q;
        pkt_d      = pkt_q;
        in_ready   = 1'b0;
        commit     = 1'b0;
        commit_pkt = pkt_q;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (in_pkt.is_store) begin
                        pkt_d   = in_pkt;
                        state_d = HOLD;
                    end else begin
                        commit     = 1'b1;
                        commit_pkt = in_pkt;
                        if (in_pkt.sim_end) begin
                            state_d = HALT;
                        end
                    end
                end
            end
            HOLD: begin
                if (store_memstage_active) begin
                    commit     = 1'b1;
                    commit_pkt = pkt_q;
                    pkt_d      = '0;
                    state_d    = pkt_q.sim_end ? HALT : IDLE;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        store_wb_flag_d = commit && commit_pkt.is_store;
    end

    // Next register-file image. Ports are applied in ascending order so the
    // highest-numbered port wins a same-index collision.
    always_comb begin
        rf_d = rf_q;
        if (commit) begin
            for (int p = 0; p < NPORTS; p++) begin
                if (commit_pkt.wen[p]) begin
                    rf_d[commit_pkt.widx[p]] = commit_pkt.wdata[p];
                end
            end
        end
    end

    // Reading from the next image gives the same-cycle commit bypass with
    // exactly the write-port priority used for the register file itself.
    always_comb begin
        rd_data = '0;
        for (int r = 0; r < NRD; r++) begin
            rd_data[r] = rf_d[rd_idx[r]];
        end
    end

    // State, parked store, flag pulse and register file. Reset wins over a
    // commit in the same cycle, which discards a store waiting in HOLD.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q         <= IDLE;
            pkt_q           <= '0;
            store_wb_flag_q <= 1'b0;
            rf_q            <= '0;
        end else begin
            state_q         <= state_d;
            pkt_q           <= pkt_d;
            store_wb_flag_q <= store_wb_flag_d;
            rf_q            <= rf_d;
        end
    end

    // Each port that actually writes retires one in-flight writer.
    always_comb begin
        dec_valid = '0;
        for (int p = 0; p < NPORTS; p++) begin
            dec_valid[p] = commit && commit_pkt.wen[p];
        end
    end

    mod_wb_scoreboard #(
        .NREGS  (NREGS),
        .CNTW   (CNTW),
        .NPORTS (NPORTS)
    ) u_scoreboard (
        .clk         (clk),
        .reset_ni    (reset),
        .set_valid_i (sb_set_valid),
        .set_idx_i   (sb_set_idx),
        .dec_valid_i (dec_valid),
        .dec_idx_i   (commit_pkt.widx),
        .busy_o      (sb_busy),
        .full_o      (sb_full)
    );

    assign store_wb_flag = store_wb_flag_q;
    assign sim_done      = (state_q == HALT);

endmodule

// File: tb/tb_mod_writeback_mp.sv
// ---------------------------------------------------------------------------
// tb_mod_writeback_mp
// Self-checking bench for mod_writeback_mp: directed scenarios followed by a
// randomized run against a behavioural model of the register file, store
// hold, flag pulse and saturating scoreboard.
// ---------------------------------------------------------------------------
module tb_mod_writeback_mp;
    import wb_pkg::*;

    localparam int NREGS = 16;
    localparam int IDXW  = 4;
    localparam int CMAX  = 3;

    logic                   clk;
    logic                   reset;
    logic                   in_valid;
    logic                   in_ready;
    wb_pkt_t                in_pkt;
    logic                   store_memstage_active;
    logic                   sb_set_valid;
    logic [IDXW-1:0]        sb_set_idx;
    logic                   sb_full;
    logic [NREGS-1:0]       sb_busy;
    logic [1:0][IDXW-1:0]   rd_idx;
    logic [1:0][63:0]       rd_data;
    logic                   store_wb_flag;
    logic                   sim_done;

    int checks   = 0;
    int failures = 0;

    // Model state for the randomized run.
    logic [63:0] mRf [NREGS];
    int          mCnt [NREGS];
    bit          mHold;
    bit          mFlag;
    wb_pkt_t     mPkt;

    mod_writeback_mp dut (
        .clk                   (clk),
        .reset                 (reset),
        .in_valid              (in_valid),
        .in_ready              (in_ready),
        .in_pkt                (in_pkt),
        .store_memstage_active (store_memstage_active),
        .sb_set_valid          (sb_set_valid),
        .sb_set_idx            (sb_set_idx),
        .sb_full               (sb_full),
        .sb_busy               (sb_busy),
        .rd_idx                (rd_idx),
        .rd_data               (rd_data),
        .store_wb_flag         (store_wb_flag),
        .sim_done              (sim_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic wb_pkt_t mkPkt(logic [1:0] wen, logic [3:0] i0, logic [3:0] i1,
                                      logic [63:0] d0, logic [63:0] d1, logic st, logic se);
        wb_pkt_t p;
        p = '0;
        p.wen      = wen;
        p.widx[0]  = i0;
        p.widx[1]  = i1;
        p.wdata[0] = d0;
        p.wdata[1] = d1;
        p.is_store = st;
        p.sim_end  = se;
        return p;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(logic v, wb_pkt_t p, logic act, logic sv, logic [3:0] si);
        in_valid              = v;
        in_pkt                = p;
        store_memstage_active = act;
        sb_set_valid          = sv;
        sb_set_idx            = si;
    endtask

    task automatic doReset();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 4'd0);
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 4'd0);
        rd_idx[0] = 4'd0;
        rd_idx[1] = 4'd15;
        reset = 1'b0;
        step();
        step();
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready: got %0b want 1", in_ready); end
        checks++; if (store_wb_flag !== 1'b0) begin failures++; $display("[TB] FAIL reset_flag: got %0b want 0", store_wb_flag); end
        checks++; if (sim_done !== 1'b0) begin failures++; $display("[TB] FAIL reset_sim_done: got %0b want 0", sim_done); end
        checks++; if (sb_busy !== 16'h0) begin failures++; $display("[TB] FAIL reset_busy: got %h want 0000", sb_busy); end
        checks++; if (sb_full !== 1'b0) begin failures++; $display("[TB] FAIL reset_full: got %0b want 0", sb_full); end
        checks++; if (rd_data[0] !== 64'h0 || rd_data[1] !== 64'h0) begin failures++; $display("[TB] FAIL reset_rf: got %h %h want 0", rd_data[0], rd_data[1]); end
        reset = 1'b1;
    endtask

    task automatic test_two_port();
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 4'd0);
        step();
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 4'd2);
        step();
        applyStimulus(1'b1, mkPkt(2'b11, 4'd0, 4'd2, 64'd5, 64'd7, 1'b0, 1'b0), 1'b0, 1'b0, 4'd0);
        rd_idx[0] = 4'd0;
        rd_idx[1] = 4'd2;
        #1;
        checks++; if (sb_busy !== 16'h0005) begin failures++; $display("[TB] FAIL two_port_busy_pre: got %h want 0005", sb_busy); end
        checks++; if (rd_data[0] !== 64'd5 || rd_data[1] !== 64'd7) begin failures++; $display("[TB] FAIL two_port_bypass: got %0d %0d want 5 7", rd_data[0], rd_data[1]); end
        step();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 4'd0);
        #1;
        checks++; if (rd_data[0] !== 64'd5 || rd_data[1] !== 64'd7) begin failures++; $display("[TB] FAIL two_port_rf: got %0d %0d want 5 7", rd_data[0], rd_data[1]); end
        checks++; if (sb_busy !== 16'h0000) begin failures++; $display("[TB] FAIL two_port_busy_post: got %h want 0000", sb_busy); end
    endtask

    task automatic test_same_idx();
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 4'd3);
        step();
        step();
        applyStimulus(1'b1, mkPkt(2'b11, 4'd3, 4'd3, 64'hAAAA, 64'hBBBB, 1'b0, 1'b0), 1'b0, 1'b0, 4'd0);
        rd_idx[0] = 4'd3;
        step();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 4'd0);
        #1;
        checks++; if (rd_data[0] !== 64'hBBBB) begin failures++; $display("[TB] FAIL same_idx_winner: got %h want bbbb", rd_data[0]); end
        checks++; if (sb_busy[3] !== 1'b1) begin failures++; $display("[TB] FAIL same_idx_single_dec: got %0b want 1", sb_busy[3]); end
        applyStimulus(1'b1, mkPkt(2'b01, 4'd3, 4'd0, 64'hCCCC, 64'h0, 1'b0, 1'b0), 1'b0, 1'b0, 4'd0);
        step();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 4'd0);
        #1;
        checks++; if (sb_busy[3] !== 1'b0 || rd_data[0] !== 64'hCCCC) begin failures++; $display("[TB] FAIL same_idx_drain: got busy=%0b data=%h want 0 cccc", sb_busy[3], rd_data[0]); end
    endtask

    task automatic test_store_hold();
        applyStimulus(1'b1, mkPkt(2'b01, 4'd7, 4'd0, 64'h7777, 64'h0, 1'b1, 1'b0), 1'b0, 1'b0, 4'd0);
        rd_idx[0] = 4'd7;
        rd_idx[1] = 4'd8;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL store_accept_ready: got %0b want 1", in_ready); end
        step();
        // A distracting non-store packet must be ignored while held.
        applyStimulus(1'b1, mkPkt(2'b01, 4'd8, 4'd0, 64'h8888, 64'h0, 1'b0, 1'b0), 1'b0, 1'b0, 4'd0);
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (in_ready !== 1'b0 || rd_data[0] !== 64'h0) begin failures++; $display("[TB] FAIL store_hold_wait%0d: got ready=%0b r7=%h want 0 0", k, in_ready, rd_data[0]); end
            step();
        end
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 4'd0);
        #1;
        checks++; if (in_ready !== 1'b0 || rd_data[0] !== 64'h7777 || store_wb_flag !== 1'b0) begin failures++; $display("[TB] FAIL store_commit_cycle: got ready=%0b r7=%h flag=%0b want 0 7777 0", in_ready, rd_data[0], store_wb_flag); end
        step();
        store_memstage_active = 1'b0;
        #1;
        checks++; if (store_wb_flag !== 1'b1 || in_ready !== 1'b1 || rd_data[0] !== 64'h7777) begin failures++; $display("[TB] FAIL store_flag_pulse: got flag=%0b ready=%0b r7=%h want 1 1 7777", store_wb_flag, in_ready, rd_data[0]); end
        checks++; if (rd_data[1] !== 64'h0) begin failures++; $display("[TB] FAIL store_ignored_pkt: got r8=%h want 0", rd_data[1]); end
        step();
        #1;
        checks++; if (store_wb_flag !== 1'b0) begin failures++; $display("[TB] FAIL store_flag_single: got %0b want 0", store_wb_flag); end
    endtask

    task automatic test_store_fast();
        applyStimulus(1'b1, mkPkt(2'b01, 4'd9, 4'd0, 64'h99, 64'h0, 1'b1, 1'b0), 1'b1, 1'b0, 4'd0);
        rd_idx[0] = 4'd9;
        step();
        in_valid = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b0 || store_wb_flag !== 1'b0 || rd_data[0] !== 64'h99) begin failures++; $display("[TB] FAIL store_fast_hold: got ready=%0b flag=%0b r9=%h want 0 0 99", in_ready, store_wb_flag, rd_data[0]); end
        step();
        store_memstage_active = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1 || store_wb_flag !== 1'b1) begin failures++; $display("[TB] FAIL store_fast_done: got ready=%0b flag=%0b want 1 1", in_ready, store_wb_flag); end
        step();
    endtask

    task automatic test_sb_saturate();
        rd_idx[0] = 4'd5;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, '0, 1'b0, 1'b1, 4'd5);
            #1;
            checks++; if (sb_full !== (k == 3)) begin failures++; $display("[TB] FAIL sat_full_%0d: got %0b want %0b", k, sb_full, (k == 3)); end
            step();
        end
        // Issue and retire on the saturated register in the same cycle.
        applyStimulus(1'b1, mkPkt(2'b01, 4'd5, 4'd0, 64'h1, 64'h0, 1'b0, 1'b0), 1'b0, 1'b1, 4'd5);
        step();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 4'd5);
        #1;
        checks++; if (sb_full !== 1'b1) begin failures++; $display("[TB] FAIL sat_set_commit: got full=%0b want 1", sb_full); end
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, mkPkt(2'b01, 4'd5, 4'd0, 64'(k + 2), 64'h0, 1'b0, 1'b0), 1'b0, 1'b0, 4'd5);
            step();
            applyStimulus(1'b0, '0, 1'b0, 1'b0, 4'd5);
            #1;
            checks++; if (sb_busy[5] !== (k < 2) || sb_full !== 1'b0) begin failures++; $display("[TB] FAIL sat_drain_%0d: got busy=%0b full=%0b want %0b 0", k, sb_busy[5], sb_full, (k < 2)); end
        end
    endtask

    task automatic test_random();
        wb_pkt_t      p;
        wb_pkt_t      cpkt;
        bit           doCommit;
        bit           act;
        logic [63:0]  vis [NREGS];
        logic [15:0]  expBusy;
        bit           expFull;
        bit           inc;
        bit           dec;
        doReset();
        for (int i = 0; i < NREGS; i++) begin
            mRf[i]  = 64'h0;
            mCnt[i] = 0;
        end
        mHold = 1'b0;
        mFlag = 1'b0;
        mPkt  = '0;
        for (int c = 0; c < 300; c++) begin
            p = '0;
            p.wen      = 2'($urandom);
            p.widx[0]  = 4'($urandom_range(0, 15));
            p.widx[1]  = ($urandom_range(0, 3) == 0) ? p.widx[0] : 4'($urandom_range(0, 15));
            p.wdata[0] = {$urandom, $urandom};
            p.wdata[1] = {$urandom, $urandom};
            p.is_store = ($urandom_range(0, 3) == 0);
            act        = ($urandom_range(0, 2) == 0);
            applyStimulus(1'($urandom_range(0, 1)), p, act, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            rd_idx[0] = 4'($urandom_range(0, 15));
            rd_idx[1] = 4'($urandom_range(0, 15));

            doCommit = 1'b0;
            cpkt     = '0;
            if (!mHold && in_valid && !p.is_store) begin
                doCommit = 1'b1;
                cpkt     = p;
            end else if (mHold && act) begin
                doCommit = 1'b1;
                cpkt     = mPkt;
            end
            vis = mRf;
            if (doCommit) begin
                for (int q = 0; q < 2; q++) begin
                    if (cpkt.wen[q]) vis[cpkt.widx[q]] = cpkt.wdata[q];
                end
            end
            for (int i = 0; i < NREGS; i++) expBusy[i] = (mCnt[i] != 0);
            expFull = (mCnt[sb_set_idx] == CMAX);

            #1;
            checks++; if (in_ready !== !mHold) begin failures++; $display("[TB] FAIL rand_ready c%0d: got %0b want %0b", c, in_ready, !mHold); end
            checks++; if (store_wb_flag !== mFlag) begin failures++; $display("[TB] FAIL rand_flag c%0d: got %0b want %0b", c, store_wb_flag, mFlag); end
            checks++; if (sb_busy !== expBusy || sb_full !== expFull) begin failures++; $display("[TB] FAIL rand_sb c%0d: got busy=%h full=%0b want %h %0b", c, sb_busy, sb_full, expBusy, expFull); end
            checks++; if (rd_data[0] !== vis[rd_idx[0]] || rd_data[1] !== vis[rd_idx[1]]) begin failures++; $display("[TB] FAIL rand_rd c%0d: got %h %h want %h %h", c, rd_data[0], rd_data[1], vis[rd_idx[0]], vis[rd_idx[1]]); end

            mFlag = doCommit && mHold;
            for (int i = 0; i < NREGS; i++) begin
                inc = sb_set_valid && (sb_set_idx == 4'(i));
                dec = doCommit && ((cpkt.wen[0] && cpkt.widx[0] == 4'(i)) || (cpkt.wen[1] && cpkt.widx[1] == 4'(i)));
                if (inc && dec) mCnt[i] = mCnt[i];
                else if (inc && mCnt[i] < CMAX) mCnt[i] = mCnt[i] + 1;
                else if (dec && mCnt[i] > 0) mCnt[i] = mCnt[i] - 1;
            end
            mRf = vis;
            if (!mHold && in_valid && p.is_store) begin
                mHold = 1'b1;
                mPkt  = p;
            end else if (mHold && act) begin
                mHold = 1'b0;
            end
            step();
        end
    endtask

    task automatic test_store_sim_end();
        doReset();
        applyStimulus(1'b1, mkPkt(2'b01, 4'd4, 4'd0, 64'h44, 64'h0, 1'b1, 1'b1), 1'b0, 1'b0, 4'd0);
        rd_idx[0] = 4'd4;
        step();
        in_valid = 1'b0;
        #1;
        checks++; if (sim_done !== 1'b0 || in_ready !== 1'b0) begin failures++; $display("[TB] FAIL store_end_hold: got done=%0b ready=%0b want 0 0", sim_done, in_ready); end
        store_memstage_active = 1'b1;
        step();
        store_memstage_active = 1'b0;
        #1;
        checks++; if (sim_done !== 1'b1 || store_wb_flag !== 1'b1 || in_ready !== 1'b0 || rd_data[0] !== 64'h44) begin failures++; $display("[TB] FAIL store_end_halt: got done=%0b flag=%0b ready=%0b r4=%h want 1 1 0 44", sim_done, store_wb_flag, in_ready, rd_data[0]); end
    endtask

    task automatic test_sim_end_halt();
        doReset();
        applyStimulus(1'b1, mkPkt(2'b01, 4'd1, 4'd0, 64'h11, 64'h0, 1'b0, 1'b1), 1'b0, 1'b1, 4'd6);
        rd_idx[0] = 4'd1;
        step();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, mkPkt(2'b01, 4'd1, 4'd0, 64'hDEAD, 64'h0, 1'b0, 1'b0), 1'b1, 1'b0, 4'd0);
            #1;
            checks++; if (sim_done !== 1'b1 || in_ready !== 1'b0 || rd_data[0] !== 64'h11) begin failures++; $display("[TB] FAIL halt_hold_%0d: got done=%0b ready=%0b r1=%h want 1 0 11", k, sim_done, in_ready, rd_data[0]); end
            step();
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 4'd6);
        reset = 1'b0;
        step();
        #1;
        checks++; if (sim_done !== 1'b0 || in_ready !== 1'b1 || sb_busy !== 16'h0 || sb_full !== 1'b0) begin failures++; $display("[TB] FAIL halt_reset_ctl: got done=%0b ready=%0b busy=%h full=%0b want 0 1 0000 0", sim_done, in_ready, sb_busy, sb_full); end
        for (int i = 0; i < NREGS; i++) begin
            rd_idx[0] = 4'(i);
            #1;
            checks++; if (rd_data[0] !== 64'h0) begin failures++; $display("[TB] FAIL halt_reset_rf%0d: got %h want 0", i, rd_data[0]); end
        end
        reset = 1'b1;
        step();
    endtask

    task automatic test_reset_in_hold();
        applyStimulus(1'b1, mkPkt(2'b01, 4'd9, 4'd0, 64'h9999, 64'h0, 1'b1, 1'b1), 1'b0, 1'b0, 4'd0);
        rd_idx[0] = 4'd9;
        step();
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 4'd0);
        reset = 1'b0;
        step();
        reset = 1'b1;
        store_memstage_active = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (store_wb_flag !== 1'b0 || in_ready !== 1'b1 || sim_done !== 1'b0 || rd_data[0] !== 64'h0) begin failures++; $display("[TB] FAIL hold_reset_%0d: got flag=%0b ready=%0b done=%0b r9=%h want 0 1 0 0", k, store_wb_flag, in_ready, sim_done, rd_data[0]); end
            step();
        end
    endtask

    initial begin
        reset = 1'b1;
        rd_idx = '0;
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 4'd0);
        test_reset();
        test_two_port();
        test_same_idx();
        test_store_hold();
        test_store_fast();
        test_sb_saturate();
        test_random();
        test_store_sim_end();
        test_sim_end_halt();
        test_reset_in_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mod_writeback_mp.md
MOD_WRITEBACK_MP -- requirements
Module: mod_writeback_mp

Interface
REQ-001 Parameter XLEN, 64, register width in bits.
REQ-002 Parameter NREGS, 16, architectural register count; IDXW = clog2(NREGS).
REQ-003 Parameter NPORTS, 2, write ports per committed packet.
REQ-004 Parameter NRD, 2, combinational read ports.
REQ-005 Parameter CNTW, 2, scoreboard in-flight counter width per register.
REQ-006 One clock; reset is synchronous and active-low.
REQ-007 clk  in  1  clock; all state updates on rising edge.
REQ-008 reset  in  1  synchronous, active-low reset.
REQ-009 in_valid  in  1  execute stage presents a packet.
REQ-010 in_ready  out  1  unit accepts the packet this cycle.
REQ-011 in_pkt  in  wb_pkt_t  per-port wen/widx/wdata, is_store, sim_end.
REQ-012 store_memstage_active  in  1  memory stage has completed the pending store.
REQ-013 sb_set_valid  in  1  decode issues an instruction writing sb_set_idx.
REQ-014 sb_set_idx  in  IDXW  destination register being issued.
REQ-015 sb_full  out  1  counter of sb_set_idx is at max; decode must stall.
REQ-016 sb_busy  out  NREGS  bit i high when counter i is nonzero.
REQ-017 rd_idx  in  NRD x IDXW  read addresses.
REQ-018 rd_data  out  NRD x XLEN  read data.
REQ-019 store_wb_flag  out  1  one-cycle pulse when a store packet commits.
REQ-020 sim_done  out  1  simulation end reached.

Function
REQ-021 Accept = in_valid && in_ready; FSM states IDLE, HOLD, HALT.
REQ-022 IDLE: in_ready=1; accepted non-store packet commits the same edge; accepted store packet is latched and FSM goes to HOLD.
REQ-023 HOLD: in_ready=0; commits latched packet on first cycle store_memstage_active=1, pulses store_wb_flag next cycle, returns to IDLE.
REQ-024 Store arriving with store_memstage_active already 1 still takes HOLD for exactly one cycle (2-cycle occupancy).
REQ-025 Commit: for each port p with wen[p], regfile[widx[p]] <= wdata[p]; visible in regfile the following cycle.
REQ-026 Two ports with the same widx: highest-numbered port wins.
REQ-027 rd_data[r] = regfile[rd_idx[r]], bypassed by any same-cycle commit to that index (same priority as REQ-026).
REQ-028 Each committed write port decrements its register's counter once; two ports to same index decrement once.
REQ-029 sb_set_valid increments counter of sb_set_idx unless sb_full; at max, increment is dropped.
REQ-030 Same-cycle increment and decrement on one register: counter unchanged.
REQ-031 Decrement at zero: counter stays 0 (no wrap).
REQ-032 Committed packet with sim_end=1: FSM to HALT, sim_done=1 next cycle; HALT holds in_ready=0 until reset.
REQ-033 sim_end on a store packet: HALT entered only after the HOLD commit.

Reset
REQ-034 On reset low at clk edge: all regfile entries 0, all counters 0, FSM IDLE, latched packet cleared.
REQ-035 Outputs during/after reset: in_ready=1, store_wb_flag=0, sim_done=0, sb_busy=0, sb_full=0.
REQ-036 Reset in HOLD discards the latched store with no register write.

Structure
REQ-037 Package wb_pkg holds wb_pkt_t, FSM enum wb_state_t and default parameter constants.
REQ-038 Scoreboard counters live in sub-module mod_wb_scoreboard (NREGS, CNTW, NPORTS).

Verification
REQ-039 Two-port packet wen=11, widx={0,2}, data={5,7} -> next cycle r0=5, r2=7; busy bits 0,2 clear.
REQ-040 Both ports widx=3, data={A,B} -> r3=B; counter 3 decremented once.
REQ-041 Store packet with store_memstage_active low 3 cycles -> in_ready=0 4 cycles, write on 4th, store_wb_flag pulse one cycle after.
REQ-042 sb_set_valid idx 5 four times with CNTW=2 -> counter 3, sb_full=1, 4th set dropped; set+commit same cycle -> stays 3.
REQ-043 sim_end packet -> sim_done=1 next cycle, in_ready=0 until reset low, then all state zero.
REQ-044 Reset asserted while in HOLD -> no regfile write, FSM IDLE, store_wb_flag never pulses.
